// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master arbiter that shares one memory bus between an
//            instruction-fetch port (i_*) and a load/store port (d_*).
//            Data requests win ties. A counter bounds how many data grants in
//            a row may occur while a fetch is waiting (STARVE_LIMIT).
//            Each transfer takes an IDLE cycle plus at least one grant cycle.
// Ports    : clk, reset (synchronous, active-high)
//            i_read, i_address            -> fetch request
//            i_readdata, i_waitrequest    <- fetch response / stall
//            d_read, d_write, d_address, d_writedata, d_byteenable -> data req
//            d_readdata, d_waitrequest    <- data response / stall
//            d_misaligned                 <- only with MEM_ARB_ALIGN_CHECK_EN
//            address, writedata, read, write, byteenable -> shared bus command
//            readdata, waitrequest        <- shared bus response
// Options  : `define MEM_ARB_ALIGN_CHECK_EN to answer data requests whose
//            address is not word aligned locally (0xDEADBEEF) instead of
//            forwarding them to the bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction port
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    // data port
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
`ifdef MEM_ARB_ALIGN_CHECK_EN
    output logic        d_misaligned,
`endif
    // shared memory bus
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    // +2 keeps the width at least one bit even for STARVE_LIMIT == 0
    localparam int                c_cnt_w        = $clog2(STARVE_LIMIT + 2);
    localparam logic [c_cnt_w-1:0] c_starve_limit = c_cnt_w'(STARVE_LIMIT);
    localparam logic [31:0]       c_misalign_data = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // latched bus command; the bus is driven only from these during a grant
    logic [31:0]        r_cmd_address;
    logic [31:0]        r_cmd_writedata;
    logic [3:0]         r_cmd_byteenable;
    logic               r_cmd_read;
    logic               r_cmd_write;
    logic [c_cnt_w-1:0] r_starve_cnt;

    logic w_d_req;        // data port asking for anything
    logic w_d_fwd;        // data request eligible for the bus
    logic w_d_local_done; // data request answered without the bus
    logic w_starved;
    logic w_i_bus_done;   // bus-level completion of an instruction grant
    logic w_d_bus_done;   // bus-level completion of a data grant
    logic w_i_port_done;  // completion visible on the instruction port
    logic w_d_port_done;  // completion visible on the data port
    logic w_load_i;
    logic w_load_d;

    assign w_d_req = d_read | d_write;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic w_d_misaligned;
    assign w_d_misaligned = w_d_req & (d_address[1:0] != 2'b00);
    assign w_d_fwd        = w_d_req & ~w_d_misaligned;
    // Misaligned requests are answered from IDLE only, so they never
    // interrupt a transfer that is already on the bus.
    assign w_d_local_done = w_d_misaligned & (r_state == ST_IDLE) & ~reset;
    assign d_misaligned   = w_d_local_done;
`else
    assign w_d_fwd        = w_d_req;
    assign w_d_local_done = 1'b0;
`endif

    assign w_starved    = (r_starve_cnt == c_starve_limit);
    assign w_i_bus_done = (r_state == ST_GRANT_I) & ~waitrequest;
    assign w_d_bus_done = (r_state == ST_GRANT_D) & ~waitrequest;

    // Reset hides a completion in the same cycle, and a port that dropped
    // its request is not told about the transfer finishing.
    assign w_i_port_done = w_i_bus_done & ~reset & i_read;
    assign w_d_port_done = w_d_bus_done & ~reset & w_d_req;

    assign w_load_i = (r_state == ST_IDLE) & (w_next_state == ST_GRANT_I);
    assign w_load_d = (r_state == ST_IDLE) & (w_next_state == ST_GRANT_D);

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // data wins a tie unless the fetch has waited long enough
                if (i_read && (!w_d_fwd || w_starved)) begin
                    w_next_state = ST_GRANT_I;
                end else if (w_d_fwd) begin
                    w_next_state = ST_GRANT_D;
                end
            end
            ST_GRANT_I,
            ST_GRANT_D: begin
                if (!waitrequest) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // command latch and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_address    <= '0;
            r_cmd_writedata  <= '0;
            r_cmd_byteenable <= '0;
            r_cmd_read       <= 1'b0;
            r_cmd_write      <= 1'b0;
        end else if (w_load_i) begin
            r_cmd_address    <= i_address;
            r_cmd_writedata  <= '0;
            r_cmd_byteenable <= 4'b1111;
            r_cmd_read       <= 1'b1;
            r_cmd_write      <= 1'b0;
        end else if (w_load_d) begin
            r_cmd_address    <= d_address;
            r_cmd_writedata  <= d_writedata;
            r_cmd_byteenable <= d_byteenable;
            r_cmd_read       <= d_read;
            r_cmd_write      <= d_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!i_read || w_i_bus_done) begin
            r_starve_cnt <= '0;
        end else if (w_d_bus_done && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // bus and port outputs
    // ------------------------------------------------------------------
    always_comb begin
        address       = r_cmd_address;
        writedata     = r_cmd_writedata;
        byteenable    = r_cmd_byteenable;
        read          = 1'b0;
        write         = 1'b0;
        i_waitrequest = i_read & ~w_i_port_done;
        i_readdata    = '0;
        d_waitrequest = w_d_req & ~w_d_port_done & ~w_d_local_done;
        d_readdata    = '0;

        if (r_state != ST_IDLE) begin
            read  = r_cmd_read;
            write = r_cmd_write;
        end
        if (w_i_port_done) begin
            i_readdata = readdata;
        end
        if (w_d_local_done) begin
            d_readdata = c_misalign_data;
        end else if (w_d_port_done) begin
            d_readdata = readdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter: directed scenarios
//            followed by randomized traffic compared against a cycle-level
//            reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        d_misaligned;
`endif
    logic [31:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .d_misaligned  (d_misaligned),
`endif
        .address       (address),
        .writedata     (writedata),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .waitrequest   (waitrequest)
    );

    always #5 clk = ~clk;

    // inputs change 1ns after the rising edge; outputs are sampled 1ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read       = 1'b0;
        i_address    = '0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        d_address    = '0;
        d_writedata  = '0;
        d_byteenable = '0;
        readdata     = '0;
        waitrequest  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // completion kind seen on the ports this cycle: 0 none, 1 fetch, 2 data
    function automatic int port_done_kind();
        if (i_read && !i_waitrequest) return 1;
        if ((d_read || d_write) && !d_waitrequest) return 2;
        return 0;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        i_read = 1'b1;
        next_cycle();
        #1;
        checks++;
        if ({read, write, i_waitrequest, d_waitrequest} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_i_req rd/wr/iw/dw got %b exp 0010",
                     {read, write, i_waitrequest, d_waitrequest});
        end
        checks++;
        if ({i_readdata, d_readdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_readdata got %h exp 0", {i_readdata, d_readdata});
        end
        i_read  = 1'b0;
        d_write = 1'b1;
        next_cycle();
        #1;
        checks++;
        if ({read, write, i_waitrequest, d_waitrequest} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_d_req rd/wr/iw/dw got %b exp 0001",
                     {read, write, i_waitrequest, d_waitrequest});
        end
        reset   = 1'b0;
        d_write = 1'b0;
        #1;
        checks++;
        if ({read, write, i_waitrequest, d_waitrequest} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle rd/wr/iw/dw got %b exp 0000",
                     {read, write, i_waitrequest, d_waitrequest});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ifetch();
        do_reset();
        i_read    = 1'b1;
        i_address = 32'hBFC0_0000;
        readdata  = 32'h2402_0005;
        #1;
        checks++;
        if ({read, i_waitrequest} !== 2'b01) begin
            errors++;
            $display("FAIL ifetch_c1 read/iwait got %b exp 01", {read, i_waitrequest});
        end
        next_cycle();
        #1;
        checks++;
        if ({read, write, byteenable, address} !== {1'b1, 1'b0, 4'hF, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL ifetch_c2_bus rd %b wr %b be %h addr %h exp 1 0 f bfc00000",
                     read, write, byteenable, address);
        end
        checks++;
        if ({i_waitrequest, i_readdata} !== {1'b0, 32'h2402_0005}) begin
            errors++;
            $display("FAIL ifetch_c2_port iwait %b data %h exp 0 24020005",
                     i_waitrequest, i_readdata);
        end
        next_cycle();
        i_read = 1'b0;
        #1;
        checks++;
        if ({read, write, i_waitrequest} !== 3'b000) begin
            errors++;
            $display("FAIL ifetch_c3_idle rd/wr/iw got %b exp 000", {read, write, i_waitrequest});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        do_reset();
        i_read       = 1'b1;
        i_address    = 32'h0040_0000;
        d_write      = 1'b1;
        d_address    = 32'h0000_1000;
        d_writedata  = 32'hCAFE_F00D;
        d_byteenable = 4'h3;
        readdata     = 32'h1111_1111;
        #1;
        checks++;
        if ({read, write, i_waitrequest, d_waitrequest} !== 4'b0011) begin
            errors++;
            $display("FAIL prio_idle rd/wr/iw/dw got %b exp 0011",
                     {read, write, i_waitrequest, d_waitrequest});
        end
        next_cycle();
        #1;
        checks++;
        if ({read, write, byteenable, address, writedata} !==
            {1'b0, 1'b1, 4'h3, 32'h0000_1000, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL prio_grant_d rd %b wr %b be %h addr %h wd %h exp 0 1 3 00001000 cafef00d",
                     read, write, byteenable, address, writedata);
        end
        checks++;
        if ({i_waitrequest, d_waitrequest} !== 2'b10) begin
            errors++;
            $display("FAIL prio_grant_d_wait iw/dw got %b exp 10", {i_waitrequest, d_waitrequest});
        end
        next_cycle();
        d_write = 1'b0;
        #1;
        checks++;
        if ({read, write, i_waitrequest} !== 3'b001) begin
            errors++;
            $display("FAIL prio_idle2 rd/wr/iw got %b exp 001", {read, write, i_waitrequest});
        end
        next_cycle();
        #1;
        checks++;
        if ({read, write, byteenable, address, i_waitrequest, i_readdata} !==
            {1'b1, 1'b0, 4'hF, 32'h0040_0000, 1'b0, 32'h1111_1111}) begin
            errors++;
            $display("FAIL prio_grant_i rd %b wr %b be %h addr %h iw %b data %h exp 1 0 f 00400000 0 11111111",
                     read, write, byteenable, address, i_waitrequest, i_readdata);
        end
        next_cycle();
        i_read = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Both ports held busy from an IDLE cycle with a cleared counter:
    // completions must come every second cycle as D D D D I, repeating.
    task automatic check_starve_pattern(input string name, input int n_cycles);
        for (int c = 0; c < n_cycles; c++) begin
            int got;
            int exp;
            got = port_done_kind();
            if (c % 2 == 0) exp = 0;
            else exp = (((c / 2) % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 1 : 2;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d completion got %0d exp %0d (1=fetch 2=data)",
                         name, c, got, exp);
            end
            next_cycle();
            #1;
        end
    endtask

    task automatic test_starvation();
        do_reset();
        i_read      = 1'b1;
        i_address   = 32'h0000_0100;
        d_read      = 1'b1;
        d_address   = 32'h0000_8000;
        readdata    = 32'h0BAD_F00D;
        waitrequest = 1'b0;
        #1;
        check_starve_pattern("starve", 4 * (STARVE_LIMIT + 1) + 2);
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wait_stall();
        do_reset();
        i_read      = 1'b1;
        i_address   = 32'h8000_1234;
        waitrequest = 1'b1;
        readdata    = 32'h7777_0001;
        #1;
        checks++;
        if ({read, i_waitrequest} !== 2'b01) begin
            errors++;
            $display("FAIL stall_idle read/iwait got %b exp 01", {read, i_waitrequest});
        end
        for (int g = 1; g <= 4; g++) begin
            next_cycle();
            waitrequest = (g < 4);
            i_address   = 32'h0000_0000 + g; // must not leak onto the bus
            #1;
            checks++;
            if ({read, address, i_waitrequest} !== {1'b1, 32'h8000_1234, (g < 4)}) begin
                errors++;
                $display("FAIL stall_g%0d read %b addr %h iwait %b exp 1 80001234 %b",
                         g, read, address, i_waitrequest, (g < 4));
            end
        end
        checks++;
        if (i_readdata !== 32'h7777_0001) begin
            errors++;
            $display("FAIL stall_data got %h exp 77770001", i_readdata);
        end
        next_cycle();
        i_read      = 1'b0;
        waitrequest = 1'b0;
        #1;
        checks++;
        if ({read, write} !== 2'b00) begin
            errors++;
            $display("FAIL stall_after rd/wr got %b exp 00", {read, write});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        i_read       = 1'b1;
        d_write      = 1'b1;
        d_address    = 32'h0000_2000;
        d_writedata  = 32'h55AA_55AA;
        d_byteenable = 4'hF;
        waitrequest  = 1'b0;
        // two data completions build up the starvation count
        repeat (4) next_cycle();
        waitrequest = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (write !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant write got %b exp 1", write);
        end
        next_cycle();
        reset       = 1'b1;
        waitrequest = 1'b0;
        readdata    = 32'h1234_5678;
        #1;
        checks++;
        if ({d_waitrequest, d_readdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_no_done dwait %b data %h exp 1 00000000", d_waitrequest, d_readdata);
        end
        next_cycle();
        reset     = 1'b0;
        d_write   = 1'b0;
        d_read    = 1'b1;
        d_address = 32'h0000_3000;
        #1;
        checks++;
        if ({read, write} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle rd/wr got %b exp 00", {read, write});
        end
        // a cleared counter means a full run of data grants before the fetch
        check_starve_pattern("rstmid_starve", 2 * (STARVE_LIMIT + 1) + 2);
        clear_inputs();
    endtask

`ifdef MEM_ARB_ALIGN_CHECK_EN
    task automatic test_misaligned();
        do_reset();
        d_read    = 1'b1;
        d_address = 32'h0000_1002;
        #1;
        checks++;
        if ({d_waitrequest, d_readdata, d_misaligned, read} !== {1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL misalign dwait %b data %h mis %b read %b exp 0 deadbeef 1 0",
                     d_waitrequest, d_readdata, d_misaligned, read);
        end
        next_cycle();
        #1;
        checks++;
        if (read !== 1'b0) begin
            errors++;
            $display("FAIL misalign_no_bus read got %b exp 0", read);
        end
        clear_inputs();
    endtask
`endif

    // ------------------------------------------------------------------
    // Reference model: who owns the bus (0 none, 1 fetch, 2 data), the
    // command captured at grant time and the consecutive-data-grant count.
    task automatic test_random();
        int          owner;
        int          starve;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;
        logic        m_rd;
        logic        m_wr;
        do_reset();
        owner = 0; starve = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_rd = 1'b0; m_wr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int   dsel;
            int   n_owner;
            int   n_starve;
            logic done;
            logic d_req;
            logic idone;
            logic ddone;
            reset        = ($urandom_range(0, 59) == 0);
            i_read       = ($urandom_range(0, 3) != 0);
            dsel         = $urandom_range(0, 3);
            d_read       = (dsel == 1) || (dsel == 3);
            d_write      = (dsel == 2);
            i_address    = $urandom;
            d_address    = $urandom;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            d_address[1:0] = 2'b00;
`endif
            d_writedata  = $urandom;
            d_byteenable = 4'($urandom_range(0, 15));
            waitrequest  = ($urandom_range(0, 2) == 0);
            readdata     = $urandom;
            #1;
            d_req = d_read || d_write;
            done  = (owner != 0) && !waitrequest;
            idone = (owner == 1) && done && !reset && i_read;
            ddone = (owner == 2) && done && !reset && d_req;

            checks++;
            if ({read, write} !== {(owner != 0) && m_rd, (owner != 0) && m_wr}) begin
                errors++;
                $display("FAIL rand%0d strobes rd/wr got %b exp %b%b", n, {read, write},
                         (owner != 0) && m_rd, (owner != 0) && m_wr);
            end
            if (owner != 0) begin
                checks++;
                if ({address, writedata, byteenable} !== {m_addr, m_wdata, m_be}) begin
                    errors++;
                    $display("FAIL rand%0d cmd addr %h wd %h be %h exp %h %h %h", n,
                             address, writedata, byteenable, m_addr, m_wdata, m_be);
                end
            end
            checks++;
            if ({i_waitrequest, i_readdata} !== {i_read && !idone, idone ? readdata : 32'h0}) begin
                errors++;
                $display("FAIL rand%0d iport wait %b data %h exp %b %h", n, i_waitrequest,
                         i_readdata, i_read && !idone, idone ? readdata : 32'h0);
            end
            checks++;
            if ({d_waitrequest, d_readdata} !== {d_req && !ddone, ddone ? readdata : 32'h0}) begin
                errors++;
                $display("FAIL rand%0d dport wait %b data %h exp %b %h", n, d_waitrequest,
                         d_readdata, d_req && !ddone, ddone ? readdata : 32'h0);
            end

            n_owner  = owner;
            n_starve = starve;
            if (reset) begin
                n_owner = 0; n_starve = 0;
                m_addr = '0; m_wdata = '0; m_be = '0; m_rd = 1'b0; m_wr = 1'b0;
            end else begin
                if (!i_read) n_starve = 0;
                else if (done && owner == 1) n_starve = 0;
                else if (done && owner == 2) n_starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
                if (owner != 0) begin
                    if (done) n_owner = 0;
                end else if (i_read && (!d_req || starve == STARVE_LIMIT)) begin
                    n_owner = 1;
                    m_addr = i_address; m_wdata = '0; m_be = 4'hF; m_rd = 1'b1; m_wr = 1'b0;
                end else if (d_req) begin
                    n_owner = 2;
                    m_addr = d_address; m_wdata = d_writedata; m_be = d_byteenable;
                    m_rd = d_read; m_wr = d_write;
                end
            end
            owner  = n_owner;
            starve = n_starve;
            next_cycle();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_priority();
        test_starvation();
        test_wait_stall();
        test_reset_mid();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        test_misaligned();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
